// File: rtl/s2_deserializer.sv
// Serial receive stage: rebuilds {addr,data} packets from sen/sd and writes them into RB2.
// Optional S2_FRAME_CHK_EN builds a sticky frame_err flag for bad frame lengths.
module s2_deserializer #(
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 18,
    parameter int NUM_PKT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sen,
    input  logic              sd,
    output logic              RB2_RW,
    output logic [ADDR_W-1:0] RB2_A,
    output logic [DATA_W-1:0] RB2_D,
    input  logic [DATA_W-1:0] RB2_Q,
    output logic              S2_done,
    output logic              frame_err
);

    localparam int         PKT_W    = ADDR_W + DATA_W;
    localparam logic [4:0] LAST_BIT = 5'(PKT_W - 1);
    localparam logic [3:0] PKT_LAST = 4'(NUM_PKT - 1);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    state_t              state, state_n;
    logic [PKT_W-1:0]    sh, sh_n, sh_in;
    logic [4:0]          cnt, cnt_n;
    logic [3:0]          pkt, pkt_n;
    logic                rw_n;
    logic [ADDR_W-1:0]   a_n;
    logic [DATA_W-1:0]   d_n;
    logic                done_n;
    logic                unused_q;

    assign unused_q = ^RB2_Q;
    assign sh_in    = {sh[PKT_W-2:0], sd};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sh      <= '0;
            cnt     <= '0;
            pkt     <= '0;
            RB2_RW  <= 1'b1;
            RB2_A   <= '0;
            RB2_D   <= '0;
            S2_done <= 1'b0;
        end else begin
            state   <= state_n;
            sh      <= sh_n;
            cnt     <= cnt_n;
            pkt     <= pkt_n;
            RB2_RW  <= rw_n;
            RB2_A   <= a_n;
            RB2_D   <= d_n;
            S2_done <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        sh_n    = sh;
        cnt_n   = cnt;
        pkt_n   = pkt;
        rw_n    = 1'b1;
        a_n     = RB2_A;
        d_n     = RB2_D;
        done_n  = S2_done;
        case (state)
            IDLE: begin
                if (!sen) begin
                    sh_n    = sh_in;
                    cnt_n   = 5'd1;
                    state_n = RECV;
                end
            end
            RECV: begin
                if (sen) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    sh_n  = sh_in;
                    cnt_n = cnt + 5'd1;
                    if (cnt == LAST_BIT) begin
                        state_n = WRITE;
                        rw_n    = 1'b0;
                        a_n     = sh_in[PKT_W-1:DATA_W];
                        d_n     = sh_in[DATA_W-1:0];
                    end
                end
            end
            WRITE: begin
                // A low sen here is bit 0 of the next packet; an over-long frame's tail
                // therefore restarts a packet that ends short and is dropped.
                pkt_n = pkt + 4'd1;
                if (pkt == PKT_LAST) begin
                    cnt_n   = '0;
                    done_n  = 1'b1;
                    state_n = DONE;
                end else if (!sen) begin
                    sh_n    = sh_in;
                    cnt_n   = 5'd1;
                    state_n = RECV;
                end else begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            end
            default: ;
        endcase
    end

`ifdef S2_FRAME_CHK_EN
    logic bad_frame;

    // sen rising mid-packet covers both short frames and the tail of an over-long one.
    assign bad_frame = (state == RECV) && sen;

    always_ff @(posedge clk) begin
        if (rst) frame_err <= 1'b0;
        else     frame_err <= frame_err | bad_frame;
    end
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_s2_deserializer.sv
// Scoreboard bench for s2_deserializer: directed packets, monitor checks each RB2 write.
module tb_s2_deserializer;

    logic        clk = 1'b0;
    logic        rst, sen, sd;
    logic        RB2_RW;
    logic [2:0]  RB2_A;
    logic [17:0] RB2_D;
    logic [17:0] RB2_Q = '0;
    logic        S2_done, frame_err;

`ifdef S2_FRAME_CHK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    s2_deserializer dut (
        .clk(clk), .rst(rst), .sen(sen), .sd(sd),
        .RB2_RW(RB2_RW), .RB2_A(RB2_A), .RB2_D(RB2_D), .RB2_Q(RB2_Q),
        .S2_done(S2_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  a;
        logic [17:0] d;
    } wr_t;

    wr_t         exp_q[$];
    logic [17:0] mem [8];
    int          cyc = 0;
    int          n_wr = 0, last_wr = 0, prev_wr = 0;
    int          n_chk = 0, n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every RB2_RW=0 cycle must match the oldest expected write.
    always @(posedge clk) begin : monitor
        wr_t e;
        #2;
        if (RB2_RW === 1'b0) begin
            n_wr++;
            prev_wr = last_wr;
            last_wr = cyc;
            mem[RB2_A] = RB2_D;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: got A=%0h D=%0h expected no write", RB2_A, RB2_D);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(RB2_A), 32'(e.a));
                chk("wr_data", 32'(RB2_D), 32'(e.d));
            end
        end
    end

    task automatic send_bit(input logic s, input logic b);
        @(negedge clk);
        sen = s;
        sd  = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1, 1'b0);
    endtask

    task automatic send_pkt(input logic [2:0] a, input logic [17:0] d, input logic expect_wr);
        logic [20:0] p;
        wr_t w;
        p = {a, d};
        w.a = a;
        w.d = d;
        if (expect_wr) exp_q.push_back(w);
        for (int i = 0; i < 21; i++) send_bit(1'b0, p[20-i]);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        sen = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rw"},   32'(RB2_RW),    32'd1);
        chk({tag, "_a"},    32'(RB2_A),     32'd0);
        chk({tag, "_d"},    32'(RB2_D),     32'd0);
        chk({tag, "_done"}, 32'(S2_done),   32'd0);
        chk({tag, "_err"},  32'(frame_err), 32'd0);
    endtask

    // Eight packets with one-cycle gaps; S2_done must rise one cycle after the last write.
    task automatic run_eight(input string tag, input logic [17:0] base);
        for (int k = 0; k < 8; k++) begin
            send_pkt(3'(k), base ^ 18'(k), 1'b1);
            send_bit(1'b1, 1'b0);
            chk({tag, "_done_early"}, 32'(S2_done), 32'd0);
        end
        send_bit(1'b1, 1'b0);
        chk({tag, "_done"}, 32'(S2_done), 32'd1);
        chk({tag, "_rw_idle"}, 32'(RB2_RW), 32'd1);
    endtask

    initial begin : timeout
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base_wr;
        rst = 1'b1;
        sen = 1'b1;
        sd  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_reset_vals("reset");

        // Nominal sequence
        run_eight("t1", 18'h2AAAA);
        for (int k = 0; k < 8; k++) chk("t1_mem", 32'(mem[k]), 32'(18'h2AAAA ^ 18'(k)));
        chk("t1_nwr", 32'(n_wr), 32'd8);

        // Back-to-back packets
        pulse_reset();
        chk("t2_done_clr", 32'(S2_done), 32'd0);
        send_pkt(3'd3, 18'h3FFFF, 1'b1);
        send_pkt(3'd5, 18'h00001, 1'b1);
        idle(3);
        chk("t2_spacing", 32'(last_wr - prev_wr), 32'd21);
        chk("t2_nwr", 32'(n_wr), 32'd10);
        chk("t2_hold_a", 32'(RB2_A), 32'd5);
        chk("t2_hold_d", 32'(RB2_D), 32'h1);
        chk("t2_err", 32'(frame_err), 32'd0);

        // Short frame then a good packet
        for (int i = 0; i < 10; i++) send_bit(1'b0, i[0]);
        idle(1);
        send_pkt(3'd2, 18'h12345, 1'b1);
        idle(2);
        chk("t3_nwr", 32'(n_wr), 32'd11);
        chk("t3_err", 32'(frame_err), 32'(EXP_ERR));

        // Over-long frame
        pulse_reset();
        chk("t6_err_clr", 32'(frame_err), 32'd0);
        send_pkt(3'd7, 18'h0F0F0, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1);
        idle(3);
        chk("t6_nwr", 32'(n_wr), 32'd12);
        chk("t6_err", 32'(frame_err), 32'(EXP_ERR));
        chk("t6_done", 32'(S2_done), 32'd0);

        // Reset mid-packet, then a full set of eight
        for (int i = 0; i < 15; i++) send_bit(1'b0, 1'b1);
        pulse_reset();
        chk_reset_vals("t4_rst");
        base_wr = n_wr;
        run_eight("t4", 18'h15555);
        chk("t4_nwr", 32'(n_wr - base_wr), 32'd8);

        // Post-done traffic must be ignored
        send_pkt(3'd1, 18'h00003, 1'b0);
        idle(3);
        chk("t5_done", 32'(S2_done), 32'd1);
        chk("t5_rw", 32'(RB2_RW), 32'd1);
        chk("t5_nwr", 32'(n_wr - base_wr), 32'd8);

        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
